// File: rtl/switch_debounce.sv
// Multi-bit DIP switch debouncer with a sticky change flag and optional per-bit edge pulses.
// Define SWITCH_EDGE_EN to build the sw_rise/sw_fall edge-detect registers.

module switch_debounce_lane #(
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic nxt,
    output logic stable
);
    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CNT - 1);

    logic        sync1, sync2;
    logic [19:0] cnt;
    logic        differ, done;

    assign differ = sync2 ^ stable;
    assign done   = differ && (cnt == CNT_MAX);
    assign nxt    = done ? sync2 : stable;

    // cnt tracks consecutive cycles of disagreement; it can never pass CNT_MAX
    // because reaching it with the bit still differing accepts the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= sw;
            sync2  <= sync1;
            stable <= nxt;
            if (!differ || done)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 20'd1;
        end
    end
endmodule

module switch_debounce #(
    parameter int DEBOUNCE_CNT = 50000,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    input  logic             sw_ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] led,
    output logic             sw_event,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] stable_d;
    logic             chg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        switch_debounce_lane #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .sw     (switch[i]),
            .nxt    (stable_nxt[i]),
            .stable (sw_stable[i])
        );
    end

    assign chg = |(sw_stable ^ stable_d);

    // stable_d lags sw_stable by one edge so event and edge outputs land the edge after a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= '0;
            stable_d <= '0;
            sw_event <= 1'b0;
        end else begin
            led      <= stable_nxt;
            stable_d <= sw_stable;
            if (chg)
                sw_event <= 1'b1;
            else if (sw_ack)
                sw_event <= 1'b0;
        end
    end

`ifdef SWITCH_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= sw_stable & ~stable_d;
            sw_fall <= ~sw_stable & stable_d;
        end
    end
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif
endmodule
